// File: rtl/ps2_host_tx.sv
`default_nettype none
//============================================================================
// Module   : ps2_host_tx
// Purpose  : PS/2 host-to-device transmitter. Runs the request-to-send
//            sequence (clock inhibit, start bit), shifts a framed command
//            out on device clock falls, checks the device ACK and guards
//            every device-paced phase with a timeout.
// Ports    : slowClk      - system clock
//            reset        - synchronous, active-high reset
//            psclk_i      - sampled PS/2 clock line
//            psclk_pull   - 1 = drive clock line low, 0 = release
//            psdata_i     - sampled PS/2 data line
//            psdata_pull  - 1 = drive data line low, 0 = release
//            command      - payload, captured when send is accepted
//            send         - single-cycle request, accepted only when idle
//            busy         - high from acceptance until back in idle
//            done         - one-cycle pulse, ACK good and bus idle
//            ack_err      - one-cycle pulse, ACK bit sampled as 1
//            timeout      - one-cycle pulse, device stopped clocking
// Revision : 1.0 - initial release
//============================================================================
module ps2_host_tx #(
    parameter int DATA_W      = 8,
    parameter int PARITY_ODD  = 1,
    parameter int INHIBIT_CYC = 100,
    parameter int TIMEOUT_CYC = 2000,
    parameter int FILTER_LEN  = 4
) (
    input  logic              slowClk,
    input  logic              reset,
    input  logic              psclk_i,
    output logic              psclk_pull,
    input  logic              psdata_i,
    output logic              psdata_pull,
    input  logic [DATA_W-1:0] command,
    input  logic              send,
    output logic              busy,
    output logic              done,
    output logic              ack_err,
    output logic              timeout
);

    // Counter sizing: large enough for the inhibit time, the timeout and
    // the bit index, plus one spare bit.
    localparam int c_MAX_AB = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int c_MAX    = (c_MAX_AB > DATA_W + 3) ? c_MAX_AB : DATA_W + 3;
    localparam int c_CNT_W  = $clog2(c_MAX) + 1;
    localparam int c_FILT_W = $clog2(FILTER_LEN + 1);
    localparam int c_SH_W   = DATA_W + 2;   // {stop, parity, data}

    localparam logic [c_CNT_W-1:0]  c_INH_LAST  = c_CNT_W'(INHIBIT_CYC - 1);
    localparam logic [c_CNT_W-1:0]  c_TO_LAST   = c_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [c_CNT_W-1:0]  c_BIT_LAST  = c_CNT_W'(DATA_W + 1);
    localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(FILTER_LEN - 1);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_INHIBIT   = 3'd1;
    localparam logic [2:0] c_S_REQ       = 3'd2;
    localparam logic [2:0] c_S_DATA      = 3'd3;
    localparam logic [2:0] c_S_ACK       = 3'd4;
    localparam logic [2:0] c_S_WAIT_IDLE = 3'd5;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic                r_clk_s1, r_clk_s2;
    logic                r_dat_s1, r_dat_s2;
    logic                r_clk_filt;
    logic [c_FILT_W-1:0] r_filt_cnt;
    logic                r_fall;
    logic                w_clk_diff;
    logic                w_filt_flip;

    always_comb begin
        w_clk_diff  = (r_clk_s2 != r_clk_filt);
        // The FILTER_LEN-th consecutive differing sample commits the change.
        w_filt_flip = w_clk_diff && (r_filt_cnt == c_FILT_LAST);
    end

    always_ff @(posedge slowClk) begin
        if (reset) begin
            // Synchronisers reset to the idle (high) line level so that no
            // spurious fall is seen right after reset.
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_clk_s1 <= psclk_i;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= psdata_i;
            r_dat_s2 <= r_dat_s1;
            r_fall   <= w_filt_flip && r_clk_filt;
            if (!w_clk_diff) begin
                r_filt_cnt <= '0;
            end else if (w_filt_flip) begin
                r_clk_filt <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + c_FILT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame construction
    // ------------------------------------------------------------------
    logic w_parity;

    always_comb begin
        w_parity = (PARITY_ODD != 0) ? ~(^command) : (^command);
    end

    // ------------------------------------------------------------------
    // Transmit state machine
    // ------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [c_SH_W-1:0]  r_shift;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [c_CNT_W-1:0] r_inh_cnt;
    logic [c_CNT_W-1:0] r_to_cnt;
    logic               r_clk_pull;
    logic               r_data_pull;
    logic               r_busy;
    logic               r_done;
    logic               r_ack_err;
    logic               r_timeout;
    logic               w_to_hit;

    always_comb begin
        w_to_hit = (r_to_cnt == c_TO_LAST);
    end

    always_ff @(posedge slowClk) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_inh_cnt   <= '0;
            r_to_cnt    <= '0;
            r_clk_pull  <= 1'b0;
            r_data_pull <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ack_err   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_timeout <= 1'b0;

            case (r_state)
                c_S_IDLE: begin
                    r_to_cnt  <= '0;
                    r_inh_cnt <= '0;
                    if (send) begin
                        r_shift    <= {1'b1, w_parity, command};
                        r_busy     <= 1'b1;
                        r_clk_pull <= 1'b1;
                        r_state    <= c_S_INHIBIT;
                    end
                end

                c_S_INHIBIT: begin
                    r_to_cnt <= '0;
                    if (r_inh_cnt == c_INH_LAST) begin
                        // Start bit and clock release change together.
                        r_clk_pull  <= 1'b0;
                        r_data_pull <= 1'b1;
                        r_bit_cnt   <= '0;
                        r_inh_cnt   <= '0;
                        r_state     <= c_S_REQ;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + c_CNT_W'(1);
                    end
                end

                c_S_REQ: begin
                    r_to_cnt <= r_fall ? '0 : r_to_cnt + c_CNT_W'(1);
                    r_state  <= c_S_DATA;
                end

                c_S_DATA: begin
                    if (r_fall) begin
                        // Pull low for a 0 bit; the stop bit (1) releases.
                        r_to_cnt    <= '0;
                        r_data_pull <= ~r_shift[0];
                        r_shift     <= r_shift >> 1;
                        r_bit_cnt   <= r_bit_cnt + c_CNT_W'(1);
                        if (r_bit_cnt == c_BIT_LAST) begin
                            r_state <= c_S_ACK;
                        end
                    end else if (w_to_hit) begin
                        r_clk_pull  <= 1'b0;
                        r_data_pull <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_busy      <= 1'b0;
                        r_to_cnt    <= '0;
                        r_state     <= c_S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_CNT_W'(1);
                    end
                end

                c_S_ACK: begin
                    if (r_fall) begin
                        r_to_cnt <= '0;
                        if (r_dat_s2) begin
                            r_ack_err <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= c_S_IDLE;
                        end else begin
                            r_state <= c_S_WAIT_IDLE;
                        end
                    end else if (w_to_hit) begin
                        r_clk_pull  <= 1'b0;
                        r_data_pull <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_busy      <= 1'b0;
                        r_to_cnt    <= '0;
                        r_state     <= c_S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_CNT_W'(1);
                    end
                end

                c_S_WAIT_IDLE: begin
                    if (r_fall) begin
                        r_to_cnt <= '0;
                    end else if (r_clk_filt && r_dat_s2) begin
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_to_cnt <= '0;
                        r_state  <= c_S_IDLE;
                    end else if (w_to_hit) begin
                        r_clk_pull  <= 1'b0;
                        r_data_pull <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_busy      <= 1'b0;
                        r_to_cnt    <= '0;
                        r_state     <= c_S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_CNT_W'(1);
                    end
                end

                default: begin
                    r_clk_pull  <= 1'b0;
                    r_data_pull <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= c_S_IDLE;
                end
            endcase
        end
    end

    assign psclk_pull  = r_clk_pull;
    assign psdata_pull = r_data_pull;
    assign busy        = r_busy;
    assign done        = r_done;
    assign ack_err     = r_ack_err;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
//============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Self-checking bench for ps2_host_tx. A behavioural PS/2 device
//            clocks frames out of the host, samples the data line on each
//            rising clock and returns an ACK; received frames, inhibit
//            length, result pulses and timeout latency are compared with
//            values computed from the frame rules.
// Revision : 1.0 - initial release
//============================================================================
module tb_ps2_host_tx;

    localparam int DATA_W      = 8;
    localparam int INHIBIT_CYC = 100;
    localparam int TIMEOUT_CYC = 2000;
    localparam int FILTER_LEN  = 4;
    // Device fall to host reaction: two synchroniser stages, FILTER_LEN
    // qualifying samples, one register for the fall pulse.
    localparam int FALL_LAT    = 3 + FILTER_LEN;

    logic        clk = 1'b0;
    logic        rst;
    logic        send_o, send_e;
    logic [7:0]  cmd;
    logic        dev_clk, dev_dat_low;
    logic        sel;              // 0 = odd-parity DUT, 1 = even-parity DUT
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_done, n_ackerr, n_to, to_cyc;

    logic clk_pull_o, dat_pull_o, busy_o, done_o, ackerr_o, to_o;
    logic clk_pull_e, dat_pull_e, busy_e, done_e, ackerr_e, to_e;

    // Open-drain line model: either side may pull low.
    wire w_line_clk_o = dev_clk & ~clk_pull_o;
    wire w_line_dat_o = ~dev_dat_low & ~dat_pull_o;
    wire w_line_clk_e = dev_clk & ~clk_pull_e;
    wire w_line_dat_e = ~dev_dat_low & ~dat_pull_e;

    wire w_clk_pull = sel ? clk_pull_e   : clk_pull_o;
    wire w_dat_pull = sel ? dat_pull_e   : dat_pull_o;
    wire w_dat_line = sel ? w_line_dat_e : w_line_dat_o;
    wire w_busy     = sel ? busy_e       : busy_o;
    wire w_done     = sel ? done_e       : done_o;
    wire w_ackerr   = sel ? ackerr_e     : ackerr_o;
    wire w_to       = sel ? to_e         : to_o;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_host_tx #(.DATA_W(DATA_W), .PARITY_ODD(1), .INHIBIT_CYC(INHIBIT_CYC),
                  .TIMEOUT_CYC(TIMEOUT_CYC), .FILTER_LEN(FILTER_LEN)) u_dut_odd (
        .slowClk(clk), .reset(rst),
        .psclk_i(w_line_clk_o), .psclk_pull(clk_pull_o),
        .psdata_i(w_line_dat_o), .psdata_pull(dat_pull_o),
        .command(cmd), .send(send_o), .busy(busy_o), .done(done_o),
        .ack_err(ackerr_o), .timeout(to_o)
    );

    ps2_host_tx #(.DATA_W(DATA_W), .PARITY_ODD(0), .INHIBIT_CYC(INHIBIT_CYC),
                  .TIMEOUT_CYC(TIMEOUT_CYC), .FILTER_LEN(FILTER_LEN)) u_dut_even (
        .slowClk(clk), .reset(rst),
        .psclk_i(w_line_clk_e), .psclk_pull(clk_pull_e),
        .psdata_i(w_line_dat_e), .psdata_pull(dat_pull_e),
        .command(cmd), .send(send_e), .busy(busy_e), .done(done_e),
        .ack_err(ackerr_e), .timeout(to_e)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference frame: data LSB first, then parity, then stop.
    function automatic logic [9:0] frame_of(input logic [7:0] c, input bit odd);
        logic p;
        p = ($countones(c) % 2 == 0) ? odd : !odd;
        return {1'b1, p, c};
    endfunction

    // Result-pulse monitor for the selected DUT.
    always @(negedge clk) begin
        if (!rst) begin
            if (w_done)   n_done++;
            if (w_ackerr) n_ackerr++;
            if (w_to) begin
                n_to++;
                to_cyc = cyc;
            end
            if (w_done || w_ackerr || w_to) check_val("busy_with_pulse", w_busy, 0);
        end
    end

    // Send a command, then act as the device for n_falls clock cycles.
    task automatic run_xfer(input bit s, input logic [7:0] c, input int half,
                            input bit ack_val, input int glitch_k, input int inj_k,
                            input int n_falls, output logic [9:0] rx,
                            output int inh, output int last_fall);
        int t;
        sel = s; n_done = 0; n_ackerr = 0; n_to = 0;
        rx = '0; inh = 0; last_fall = 0;
        @(negedge clk);
        cmd = c;
        if (s) send_e = 1'b1; else send_o = 1'b1;
        @(negedge clk);
        send_e = 1'b0; send_o = 1'b0;
        check_val("busy_after_send", w_busy, 1);
        t = 0;
        while (!w_clk_pull && t < 200) begin @(negedge clk); t++; end
        check_val("inhibit_seen", w_clk_pull, 1);
        while (w_clk_pull && inh < 1000) begin @(negedge clk); inh++; end
        repeat (20) @(negedge clk);
        check_val("start_bit", w_dat_line, 0);
        for (int k = 1; k <= n_falls; k++) begin
            if (k == 11) dev_dat_low = !ack_val;
            dev_clk = 1'b0;
            last_fall = cyc;
            if (k == inj_k) begin
                cmd = 8'h00;
                if (s) send_e = 1'b1; else send_o = 1'b1;
                @(negedge clk);
                send_e = 1'b0; send_o = 1'b0;
            end
            repeat (half) @(negedge clk);
            if (k <= 10) rx[k-1] = w_dat_line;
            dev_clk = 1'b1;
            if (k == glitch_k) begin
                repeat (10) @(negedge clk);
                dev_clk = 1'b0;
                repeat (2) @(negedge clk);
                dev_clk = 1'b1;
                repeat (half - 12) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_pulse(input int max_cyc);
        int t = 0;
        while ((n_done + n_ackerr + n_to) == 0 && t < max_cyc) begin
            @(negedge clk); t++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic full_xfer(input string tag, input bit s, input logic [7:0] c,
                             input int half, input int glitch_k, input int inj_k,
                             input logic [9:0] exp_frame);
        logic [9:0] rx;
        int inh, lf;
        run_xfer(s, c, half, 1'b0, glitch_k, inj_k, 11, rx, inh, lf);
        wait_pulse(300);
        check_val({tag, "_inhibit"}, inh, INHIBIT_CYC);
        check_val({tag, "_frame"}, rx, exp_frame);
        check_val({tag, "_done"}, n_done, 1);
        check_val({tag, "_noerr"}, n_ackerr + n_to, 0);
        check_val({tag, "_busy_end"}, w_busy, 0);
        check_val({tag, "_pulls_end"}, {w_clk_pull, w_dat_pull}, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  rx;
        int          inh, lf, t;
        logic [7:0]  rc;
        bit          rs;
        int          rh;

        rst = 1'b1; send_o = 1'b0; send_e = 1'b0; cmd = '0;
        dev_clk = 1'b1; dev_dat_low = 1'b0; sel = 1'b0;
        n_done = 0; n_ackerr = 0; n_to = 0; to_cyc = 0;
        repeat (5) @(negedge clk);
        check_val("rst_clk_pull", clk_pull_o, 0);
        check_val("rst_dat_pull", dat_pull_o, 0);
        check_val("rst_busy", busy_o, 0);
        check_val("rst_done", done_o, 0);
        check_val("rst_ack_err", ackerr_o, 0);
        check_val("rst_timeout", to_o, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Directed frames with known parity
        full_xfer("ed", 0, 8'hED, 40, 0, 0, 10'h3ED);
        full_xfer("f4_odd", 0, 8'hF4, 40, 0, 0, 10'h2F4);
        full_xfer("f4_even", 1, 8'hF4, 40, 0, 0, 10'h3F4);

        // Randomised commands, parity mode and device clock rate
        for (int i = 0; i < 6; i++) begin
            rc = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            rh = int'($urandom_range(20, 60));
            full_xfer("rand", rs, rc, rh, 0, 0, frame_of(rc, !rs));
        end

        // Device answers with ACK = 1
        run_xfer(0, 8'h3C, 40, 1'b1, 0, 0, 11, rx, inh, lf);
        wait_pulse(300);
        check_val("ackerr_pulse", n_ackerr, 1);
        check_val("ackerr_no_done", n_done, 0);
        check_val("ackerr_pulls", {clk_pull_o, dat_pull_o}, 0);
        check_val("ackerr_busy", busy_o, 0);

        // Device stops clocking after the 5th fall
        run_xfer(0, 8'h5A, 40, 1'b0, 0, 0, 5, rx, inh, lf);
        t = 0;
        while (n_to == 0 && t < TIMEOUT_CYC + 200) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        check_val("to_pulse", n_to, 1);
        check_val("to_latency", to_cyc - lf, FALL_LAT + TIMEOUT_CYC);
        check_val("to_partial_bits", rx[4:0], 5'h1A);
        check_val("to_pulls", {clk_pull_o, dat_pull_o}, 0);
        check_val("to_busy", busy_o, 0);
        check_val("to_no_done", n_done, 0);

        // send during DATA is ignored; original frame completes
        full_xfer("send_busy", 0, 8'hA5, 40, 0, 3, frame_of(8'hA5, 1));

        // Short psclk glitch mid-frame shifts no extra bit
        full_xfer("glitch", 0, 8'h96, 40, 4, 0, frame_of(8'h96, 1));

        // Reset at the 6th fall
        run_xfer(0, 8'h81, 40, 1'b0, 0, 0, 5, rx, inh, lf);
        dev_clk = 1'b0;
        repeat (FALL_LAT + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_pulls", {clk_pull_o, dat_pull_o}, 0);
        check_val("midrst_busy", busy_o, 0);
        rst = 1'b0;
        dev_clk = 1'b1;
        repeat (20) @(negedge clk);
        check_val("midrst_no_pulse", n_done + n_ackerr + n_to, 0);
        full_xfer("after_rst", 0, 8'hFF, 40, 0, 0, 10'h3FF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
